// File: rtl/sort4_sequencer.sv
// rtl/sort4_sequencer.sv - four-word ascending sorter using one shared comparator.
// Loads four bytes, bubble-sorts them one compare-and-swap per clock, then streams them out.

module sort4_cmp (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       gr,
    output logic       eq
);
    assign gr = (a > b);
    assign eq = (a == b);
endmodule

module sort4_sequencer #(
    parameter logic SIGNED = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       ready,
    output logic       busy,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       done,
    output logic [2:0] swap_count
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SORT, S_DRAIN} state_t;

    state_t     state, state_next;
    logic [7:0] r [0:3];
    logic [1:0] idx;
    logic [1:0] j;
    logic [1:0] j_nx;
    logic [1:0] pass;
    logic       swapped;
    logic [1:0] k;
    logic [7:0] dout_hold;

    logic [7:0] sign_mask;
    logic [7:0] cmp_a;
    logic [7:0] cmp_b;
    logic       gr;
    logic       eq;
    logic       do_swap;
    logic       do_repass;

    // Flipping the sign bit maps two's complement onto unsigned ordering.
    assign sign_mask = SIGNED ? 8'h80 : 8'h00;
    assign j_nx      = j + 2'd1;
    assign cmp_a     = r[j] ^ sign_mask;
    assign cmp_b     = r[j_nx] ^ sign_mask;

    sort4_cmp u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .gr (gr),
        .eq (eq)
    );

    assign do_swap   = gr && !eq;
    assign do_repass = (swapped || do_swap) && (pass < 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        dout_valid = 1'b0;
        done       = 1'b0;
        dout       = dout_hold;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (din_valid && idx == 2'd3) begin
                    state_next = S_SORT;
                end
            end
            S_SORT: begin
                busy = 1'b1;
                if (j == 2'd2 && !do_repass) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy       = 1'b1;
                dout_valid = 1'b1;
                dout       = r[k];
                done       = (k == 2'd3);
                if (k == 2'd3) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r[i] <= 8'h00;
            end
            idx        <= 2'd0;
            j          <= 2'd0;
            pass       <= 2'd0;
            swapped    <= 1'b0;
            k          <= 2'd0;
            swap_count <= 3'd0;
            dout_hold  <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx        <= 2'd0;
                        swap_count <= 3'd0;
                    end
                end
                S_LOAD: begin
                    if (din_valid) begin
                        r[idx] <= din;
                        idx    <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            j       <= 2'd0;
                            pass    <= 2'd0;
                            swapped <= 1'b0;
                        end
                    end
                end
                S_SORT: begin
                    if (do_swap) begin
                        r[j]       <= r[j_nx];
                        r[j_nx]    <= r[j];
                        swap_count <= swap_count + 3'd1;
                    end
                    if (j == 2'd2) begin
                        if (do_repass) begin
                            pass    <= pass + 2'd1;
                            j       <= 2'd0;
                            swapped <= 1'b0;
                        end else begin
                            k <= 2'd0;
                        end
                    end else begin
                        j       <= j_nx;
                        swapped <= swapped || do_swap;
                    end
                end
                S_DRAIN: begin
                    dout_hold <= r[k];
                    k         <= k + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sort4_sequencer.sv
// tb/tb_sort4_sequencer.sv - directed bench for sort4_sequencer, signed and unsigned instances.

module tb_sort4_sequencer;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] din;
    logic       din_valid;

    logic       ready_s, busy_s, dout_valid_s, done_s;
    logic [7:0] dout_s;
    logic [2:0] swap_count_s;
    logic       ready_u, busy_u, dout_valid_u, done_u;
    logic [7:0] dout_u;
    logic [2:0] swap_count_u;

    int n_cmp = 0;
    int n_bad = 0;

    sort4_sequencer #(.SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
        .ready(ready_s), .busy(busy_s), .dout(dout_s), .dout_valid(dout_valid_s),
        .done(done_s), .swap_count(swap_count_s)
    );

    sort4_sequencer #(.SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
        .ready(ready_u), .busy(busy_u), .dout(dout_u), .dout_valid(dout_valid_u),
        .done(done_u), .swap_count(swap_count_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // w and the expected vectors are packed first-word-in-MSB.
    task automatic run_job(input string name, input logic [31:0] w, input logic gap,
                           input logic poke, input int exp_cycles,
                           input logic [31:0] exp_s, input logic [2:0] swaps_s,
                           input logic [31:0] exp_u, input logic [2:0] swaps_u);
        int cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        check({name, ".ready"}, {30'd0, ready_s, ready_u}, 32'h3);
        check({name, ".swap_clr"}, {26'd0, swap_count_s, swap_count_u}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            din       = w[8*(3-i) +: 8];
            din_valid = 1'b1;
            step();
            din_valid = 1'b0;
            if (gap && i == 1) begin
                din = 8'hEE;
                step();
                step();
                check({name, ".gap_hold"}, {30'd0, ready_s, ready_u}, 32'h3);
            end
        end
        check({name, ".sorting"}, {28'd0, ready_s, busy_s, ready_u, busy_u}, 32'h5);
        cnt = 0;
        while (!dout_valid_s && cnt < 20) begin
            if (poke && cnt == 1) start = 1'b1;
            step();
            start = 1'b0;
            cnt++;
        end
        check({name, ".sort_cycles"}, cnt, exp_cycles);
        for (int k = 0; k < 4; k++) begin
            check({name, ".valid"}, {30'd0, dout_valid_s, dout_valid_u}, 32'h3);
            check({name, ".dout_s"}, dout_s, exp_s[8*(3-k) +: 8]);
            check({name, ".dout_u"}, dout_u, exp_u[8*(3-k) +: 8]);
            check({name, ".done"}, {30'd0, done_s, done_u}, (k == 3) ? 32'h3 : 32'h0);
            if (poke && (k == 1 || k == 3)) start = 1'b1;
            step();
            start = 1'b0;
        end
        check({name, ".idle"}, {28'd0, busy_s, dout_valid_s, busy_u, dout_valid_u}, 32'h0);
        check({name, ".dout_hold"}, {16'd0, dout_s, dout_u}, {16'd0, exp_s[7:0], exp_u[7:0]});
        check({name, ".swaps"}, {26'd0, swap_count_s, swap_count_u}, {26'd0, swaps_s, swaps_u});
        step();
        check({name, ".stay_idle"}, {30'd0, busy_s, busy_u}, 32'h0);
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        start     = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;
        #1;
        check("reset.ctrl", {26'd0, ready_s, busy_s, dout_valid_s, done_s, ready_u, busy_u},
              32'h0);
        check("reset.data", {13'd0, dout_s, swap_count_s, dout_u, swap_count_u}, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        run_job("example", 32'h05030901, 1'b0, 1'b0, 9, 32'h01030509, 3'd4, 32'h01030509, 3'd4);
        run_job("sorted", 32'h01020304, 1'b0, 1'b0, 3, 32'h01020304, 3'd0, 32'h01020304, 3'd0);
        run_job("dups", 32'h07070707, 1'b0, 1'b0, 3, 32'h07070707, 3'd0, 32'h07070707, 3'd0);
        run_job("reverse_gap", 32'h04030201, 1'b1, 1'b0, 9, 32'h01020304, 3'd6,
                32'h01020304, 3'd6);
        run_job("sign", 32'hFF7F8000, 1'b0, 1'b0, 9, 32'h80FF007F, 3'd3, 32'h007F80FF, 3'd5);

        din       = 8'hAA;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        check("idle_din_valid", {30'd0, busy_s, ready_s}, 32'h0);
        run_job("strobes", 32'h08060705, 1'b0, 1'b1, 9, 32'h05060708, 3'd5, 32'h05060708, 3'd5);

        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din       = 8'h05 + 8'(i);
            din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
        repeat (4) step();
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst.ctrl", {26'd0, ready_s, busy_s, dout_valid_s, done_s, ready_u, busy_u},
              32'h0);
        check("midrst.data", {13'd0, dout_s, swap_count_s, dout_u, swap_count_u}, 32'h0);
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (dout_valid_s || dout_valid_u || busy_s) seen++;
            step();
        end
        check("midrst.no_output", seen, 0);
        run_job("after_rst", 32'h02010403, 1'b0, 1'b0, 6, 32'h01020304, 3'd2,
                32'h01020304, 3'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
